// File: rtl/ir_queue.sv
// ir_queue: instruction register fed by a FIFO prefetch queue with bypass and flush
module ir_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             IRWre,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             ir_valid,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       sa,
  output logic [15:0]      imm,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic push, pop, bypass;
  assign in_ready = count < CW'(DEPTH);
  assign pop = IRWre && count != '0;
  // an empty-queue load takes the incoming word directly instead of enqueuing it
  assign bypass = IRWre && count == '0 && in_valid;
  assign push = in_valid && in_ready && !bypass;
  assign op  = result[31:26];
  assign rs  = result[25:21];
  assign rt  = result[20:16];
  assign rd  = result[15:11];
  assign sa  = result[10:6];
  assign imm = result[15:0];
  always_ff @(posedge CLK)
    if (RST && !flush && push) mem[wr_ptr] <= in_data;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      result <= '0;
      ir_valid <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ir_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (IRWre) begin
        result <= pop ? mem[rd_ptr] : bypass ? in_data : result;
        ir_valid <= pop || bypass;
      end
    end
  end
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: scoreboard bench for ir_queue with a behavioural queue model
module tb_ir_queue;
  logic CLK = 0;
  logic RST = 0;
  logic [31:0] in_data = 0;
  logic in_valid = 0, IRWre = 0, flush = 0;
  logic in_ready, ir_valid;
  logic [31:0] result;
  logic [5:0] op;
  logic [4:0] rs, rt, rd, sa;
  logic [15:0] imm;
  logic [2:0] count;
  int n_tests = 0, n_fail = 0;
  logic [31:0] mq[$];
  logic [31:0] sb[$];
  logic [31:0] exp_ir = 0;
  logic exp_v = 0;

  ir_queue #(.WIDTH(32), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .IRWre(IRWre), .flush(flush), .result(result), .ir_valid(ir_valid),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm(imm), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    check("result", result, exp_ir);
    check("ir_valid", 32'(ir_valid), 32'(exp_v));
    check("count", 32'(count), 32'(mq.size()));
    check("in_ready", 32'(in_ready), 32'(mq.size() < 4));
    check("op", 32'(op), 32'(exp_ir[31:26]));
    check("rs", 32'(rs), 32'(exp_ir[25:21]));
    check("rt", 32'(rt), 32'(exp_ir[20:16]));
    check("rd", 32'(rd), 32'(exp_ir[15:11]));
    check("sa", 32'(sa), 32'(exp_ir[10:6]));
    check("imm", 32'(imm), 32'(exp_ir[15:0]));
  endtask

  task automatic do_reset();
    RST = 0;
    repeat (2) begin
      in_valid = 1'($urandom); IRWre = 1'($urandom); flush = 1'($urandom); in_data = $urandom;
      @(posedge CLK); #1;
    end
    mq.delete(); sb.delete(); exp_ir = 0; exp_v = 0;
    RST = 1; in_valid = 0; IRWre = 0; flush = 0; in_data = 0;
    check_state();
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic ld, input logic fl);
    int sz;
    bit loaded;
    logic [31:0] w;
    in_valid = v; in_data = d; IRWre = ld; flush = fl;
    sz = mq.size();
    loaded = 0;
    if (fl) begin
      mq.delete();
      exp_v = 0;
    end else begin
      if (ld && sz > 0) begin
        sb.push_back(mq.pop_front());
        loaded = 1;
      end else if (ld && v) begin
        sb.push_back(d);
        loaded = 1;
      end else if (ld) exp_v = 0;
      if (v && sz < 4 && !(ld && sz == 0)) mq.push_back(d);
    end
    @(posedge CLK); #1;
    if (loaded) begin
      w = sb.pop_front();
      check("sb_load", result, w);
      exp_ir = w;
      exp_v = 1;
    end
    check_state();
  endtask

  initial begin
    logic [31:0] prog[4];
    prog[0] = 32'h8C220004; prog[1] = 32'h00430820; prog[2] = 32'h1022FFFE; prog[3] = 32'h08000010;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, prog[i], 0, 0);
    check("full_count", 32'(count), 32'd4);
    cyc(1, 32'hDEADBEEF, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0);
      check("drain_order", result, prog[i]);
      if (i == 1) begin
        check("f_op", 32'(op), 0); check("f_rs", 32'(rs), 2); check("f_rt", 32'(rt), 3);
        check("f_rd", 32'(rd), 1); check("f_sa", 32'(sa), 0); check("f_imm", 32'(imm), 32'h0820);
      end
    end
    check("drained", 32'(count), 0);
    cyc(1, 32'h2001000A, 1, 0);
    check("bypass_imm", 32'(imm), 32'h000A);
    check("bypass_count", 32'(count), 0);
    cyc(0, 0, 1, 0);
    check("empty_hold", result, 32'h2001000A);
    check("empty_irv", 32'(ir_valid), 0);
    cyc(1, 32'hA0000001, 0, 0);
    cyc(1, 32'hA0000002, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 32'h11111111 * (i + 1), 1, 0);
      check("pp_count", 32'(count), 2);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check("pp_last", result, 32'h88888888);
    for (int i = 0; i < 3; i++) cyc(1, 32'hB0000000 + i, 0, 0);
    cyc(1, 32'hBADBAD00, 1, 1);
    check("flush_count", 32'(count), 0);
    check("flush_hold", result, 32'h88888888);
    cyc(1, 32'hCAFE0001, 0, 0);
    cyc(0, 0, 1, 0);
    check("post_flush", result, 32'hCAFE0001);
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 15) == 0));
    cyc(1, 32'h12345678, 0, 0);
    do_reset();
    cyc(0, 0, 1, 0);
    check("reset_discard", result, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with a FIFO prefetch queue in front of it, for the multi-cycle CPU fetch path. It decouples instruction-memory reads from the control unit's `IRWre` strobe. Fetched words are buffered, and on each `IRWre` the oldest one is loaded into the instruction register. MIPS-format fields of the held instruction are presented as registered outputs. A `flush` input discards all buffered work on a branch or jump redirect.

## Interface
Parameters:
- `WIDTH`, default 32: instruction word width. Must be ≥ 32; fields are decoded from bits [31:0].
- `DEPTH`, default 4: queue entries. Must be a power of two, ≥ 2.
- `CW`, default $clog2(DEPTH)+1: width of `count`.

Ports:
- `CLK`  in  1: clock. All state changes on the rising edge.
- `RST`  in  1: reset, synchronous, active-low.
- `in_data`  in  WIDTH: fetched instruction word.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_ready`  out  1: queue can accept a word. Equals `count < DEPTH`.
- `IRWre`  in  1: load the next instruction into the IR.
- `flush`  in  1: discard the queue contents and invalidate the IR.
- `result`  out  WIDTH: instruction register.
- `ir_valid`  out  1: `result` holds an instruction loaded by the most recent `IRWre`.
- `op`  out  6: `result[31:26]`.
- `rs`  out  5: `result[25:21]`.
- `rt`  out  5: `result[20:16]`.
- `rd`  out  5: `result[15:11]`.
- `sa`  out  5: `result[10:6]`.
- `imm`  out  16: `result[15:0]`.
- `count`  out  CW: number of occupied queue entries, 0..DEPTH.

## Operation
- Storage is a circular buffer of DEPTH words with a read pointer and a write pointer, each log2(DEPTH) bits wide. Both pointers wrap from DEPTH-1 to 0.
- Push: `in_valid && in_ready` writes `in_data` at the write pointer, then increments the write pointer.
- `in_ready` is derived from the registered `count` only. It gets no credit for a pop in the same cycle, so a full queue refuses input even while `IRWre` is high.
- Load, when `IRWre=1`, in priority order:
  1. If `count > 0`: `result <= head entry`, pop (advance the read pointer), `ir_valid <= 1`.
  2. Else if `in_valid`: bypass, so `result <= in_data`, `ir_valid <= 1`, and the word is not enqueued. `in_ready` is 1 in this case, and the handshake counts as consumed.
  3. Else: `result` holds its value and `ir_valid <= 0`.
- When `IRWre=0`, `result` and `ir_valid` hold their values.
- Push and pop in the same cycle (the queue is non-empty and not full): `count` is unchanged and both pointers advance.
- Flush has priority over push and load:
  - Pointers, `count`, and `ir_valid` clear to 0.
  - `result` holds its value.
  - Any `in_data` presented in the flush cycle is dropped, even though `in_ready` may be 1.
- `op`/`rs`/`rt`/`rd`/`sa`/`imm` are continuous slices of `result`, so they have no extra latency.

## Timing
- Reset (`RST=0` at a rising edge) sets `result=0`, `ir_valid=0`, `count=0`, both pointers to 0, and `in_ready=1`. All field outputs read 0. Reset overrides `flush`, `IRWre`, and `in_valid`.
- Reset mid-operation discards queued words. The queue array contents need not be cleared.
- Latency:
  - A word enqueued in cycle N can load into `result` via `IRWre` in cycle N+1 at the earliest.
  - A bypass load shows `in_data` on `result` one edge after the cycle where `IRWre && in_valid && count==0`.
- Throughput: one push and one load per cycle, sustained.
- Full boundary: at `count==DEPTH`, `in_ready=0`, and `in_valid` is ignored (no overwrite).
- Empty boundary: at `count==0` with `IRWre` and no `in_valid`, `ir_valid` drops to 0 and `result` is unchanged.
- `count` never exceeds DEPTH and never underflows.

## Test plan
- **Reset:** drive `RST=0` for 2 cycles with random inputs → `result=0`, `ir_valid=0`, `count=0`, `in_ready=1`.
- **Fill and drain:** with DEPTH=4, push 0x8C220004, 0x00430820, 0x1022FFFE, 0x08000010 → `count=4`, `in_ready=0`. A 5th push of 0xDEADBEEF is ignored. Then 4 `IRWre` pulses load the four words in order. For 0x00430820: `op=0`, `rs=2`, `rt=3`, `rd=1`, `sa=0`, `imm=0x0820`. Final `count=0`.
- **Bypass:** empty queue, `IRWre=1`, `in_valid=1`, `in_data=0x2001000A` → next cycle `result=0x2001000A`, `ir_valid=1`, `count=0`, `imm=0x000A`.
- **Simultaneous push and pop:** `count=2`, push 0x11111111 with `IRWre=1` → `count` stays 2, `result` = old head. Keep this up for 8 cycles to exercise pointer wrap-around; FIFO order is preserved.
- **Flush:** `count=3` with flush, `in_valid`, and `IRWre` all high → `count=0`, `ir_valid=0`, `result` unchanged, incoming word dropped. The next push and load returns the new word.
- **Empty load:** `count=0`, `IRWre=1`, `in_valid=0` → `ir_valid=0`, `result` holds the prior instruction.
